// File: rtl/encoder_pkg.sv
// Shared types and constants for the matrix encoder round scheduler.
// Stage indices fix the order in which the function blocks run within a round.
package encoder_pkg;

  localparam int DEF_ADDR_W = 6;
  localparam int DEF_LINE_W = 25;
  localparam int ROUND_W    = 5;
  localparam int STG_IDX_W  = 3;

  localparam logic [STG_IDX_W-1:0] STG_COLPAR = 3'd0;
  localparam logic [STG_IDX_W-1:0] STG_ROT    = 3'd1;
  localparam logic [STG_IDX_W-1:0] STG_PERM   = 3'd2;
  localparam logic [STG_IDX_W-1:0] STG_REVAL  = 3'd3;
  localparam logic [STG_IDX_W-1:0] STG_ADDRC  = 3'd4;

  typedef enum logic [1:0] {
    IDLE,
    LAUNCH,
    WAIT,
    DONE
  } sched_state_e;

endpackage

// File: rtl/encoder_round_sched_if.sv
// Control, stage-handshake and memory-write bundle of the round scheduler.
// master = scheduler side, slave = controller plus function stages.
interface encoder_round_sched_if
  import encoder_pkg::*;
#(
  parameter int NUM_STG = 5,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int LINE_W  = DEF_LINE_W
);

  logic                      start;
  logic                      busy;
  logic                      done;
  logic                      error;
  logic [ROUND_W-1:0]        round_idx;
  logic [STG_IDX_W-1:0]      stage_idx;
  logic [NUM_STG-1:0]        stg_start;
  logic [NUM_STG-1:0]        stg_done;
  logic [NUM_STG*ADDR_W-1:0] stg_addr;
  logic [NUM_STG-1:0]        stg_wr_en;
  logic [NUM_STG*LINE_W-1:0] stg_wr_val;
  logic [ADDR_W-1:0]         mem_addr;
  logic                      mem_wr_en;
  logic [LINE_W-1:0]         mem_wr_data;

  modport master (
    input  start, stg_done, stg_addr, stg_wr_en, stg_wr_val,
    output busy, done, error, round_idx, stage_idx, stg_start,
           mem_addr, mem_wr_en, mem_wr_data
  );

  modport slave (
    output start, stg_done, stg_addr, stg_wr_en, stg_wr_val,
    input  busy, done, error, round_idx, stage_idx, stg_start,
           mem_addr, mem_wr_en, mem_wr_data
  );

endinterface

// File: rtl/sched_mem_mux.sv
// Selects the active stage's address and write signals from the packed stage buses.
// Outputs are forced to zero whenever no stage owns the memory port.
module sched_mem_mux #(
  parameter int NUM_STG = 5,
  parameter int ADDR_W  = 6,
  parameter int LINE_W  = 25,
  parameter int SEL_W   = 3
) (
  input  logic                      en,
  input  logic [SEL_W-1:0]          sel,
  input  logic [NUM_STG*ADDR_W-1:0] stg_addr,
  input  logic [NUM_STG-1:0]        stg_wr_en,
  input  logic [NUM_STG*LINE_W-1:0] stg_wr_val,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic                      mem_wr_en,
  output logic [LINE_W-1:0]         mem_wr_data
);

  always_comb begin
    // NOTE: every output gets a default before the conditional so no path infers a latch.
    mem_addr    = '0;
    mem_wr_en   = 1'b0;
    mem_wr_data = '0;
    if (en && (int'(sel) < NUM_STG)) begin
      mem_addr    = stg_addr[int'(sel)*ADDR_W +: ADDR_W];
      mem_wr_en   = stg_wr_en[sel];
      mem_wr_data = stg_wr_val[int'(sel)*LINE_W +: LINE_W];
    end
  end

endmodule

// File: rtl/encoder_round_sched.sv
// Round scheduler: launches each function stage in turn for ROUNDS rounds, owns the
// shared memory write port, and aborts with a sticky error if a stage hangs.
module encoder_round_sched
  import encoder_pkg::*;
#(
  parameter int NUM_STG = 5,
  parameter int ROUNDS  = 24,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int LINE_W  = DEF_LINE_W,
  parameter int TIMEOUT = 255
) (
  input logic                    clk,
  input logic                    rst,
  encoder_round_sched_if.master  bus
);

  localparam int                    WD_W     = $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0]       WD_LAST  = WD_W'(TIMEOUT - 1);
  localparam logic [STG_IDX_W-1:0]  LAST_STG = STG_IDX_W'(NUM_STG - 1);
  localparam logic [ROUND_W-1:0]    LAST_RND = ROUND_W'(ROUNDS - 1);

  sched_state_e         state_q, state_nxt;
  logic [ROUND_W-1:0]   round_q, round_nxt;
  logic [STG_IDX_W-1:0] stage_q, stage_nxt;
  logic                 error_q, error_nxt;
  logic [WD_W-1:0]      wdog_q, wdog_nxt;
  logic [NUM_STG-1:0]   stage_oh;
  logic [NUM_STG-1:0]   stg_start_c;
  logic                 active_done;

  // Only the active stage's done line is ever looked at.
  assign stage_oh    = NUM_STG'(1) << stage_q;
  assign active_done = |(bus.stg_done & stage_oh);

  always_comb begin
    state_nxt   = state_q;
    round_nxt   = round_q;
    stage_nxt   = stage_q;
    error_nxt   = error_q;
    wdog_nxt    = wdog_q;
    stg_start_c = '0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_nxt = LAUNCH;
          round_nxt = '0;
          stage_nxt = STG_COLPAR;
          error_nxt = 1'b0;
        end
      end
      LAUNCH: begin
        stg_start_c = stage_oh;
        wdog_nxt    = '0;
        state_nxt   = WAIT;
      end
      WAIT: begin
        wdog_nxt = wdog_q + WD_W'(1);
        // A done in the expiry cycle still counts: done has priority over timeout.
        if (active_done) begin
          if (stage_q != LAST_STG) begin
            stage_nxt = stage_q + STG_IDX_W'(1);
            state_nxt = LAUNCH;
          end else if (round_q != LAST_RND) begin
            round_nxt = round_q + ROUND_W'(1);
            stage_nxt = STG_COLPAR;
            state_nxt = LAUNCH;
          end else begin
            state_nxt = DONE;
          end
        end else if (wdog_q == WD_LAST) begin
          error_nxt = 1'b1;
          state_nxt = IDLE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      state_q <= IDLE;
      round_q <= '0;
      stage_q <= STG_COLPAR;
      error_q <= 1'b0;
      wdog_q  <= '0;
    end else begin
      state_q <= state_nxt;
      round_q <= round_nxt;
      stage_q <= stage_nxt;
      error_q <= error_nxt;
      wdog_q  <= wdog_nxt;
    end
  end

  assign bus.busy      = (state_q != IDLE);
  assign bus.done      = (state_q == DONE);
  assign bus.error     = error_q;
  assign bus.round_idx = round_q;
  assign bus.stage_idx = stage_q;
  assign bus.stg_start = stg_start_c;

  sched_mem_mux #(
    .NUM_STG (NUM_STG),
    .ADDR_W  (ADDR_W),
    .LINE_W  (LINE_W),
    .SEL_W   (STG_IDX_W)
  ) u_mem_mux (
    .en          ((state_q == LAUNCH) || (state_q == WAIT)),
    .sel         (stage_q),
    .stg_addr    (bus.stg_addr),
    .stg_wr_en   (bus.stg_wr_en),
    .stg_wr_val  (bus.stg_wr_val),
    .mem_addr    (bus.mem_addr),
    .mem_wr_en   (bus.mem_wr_en),
    .mem_wr_data (bus.mem_wr_data)
  );

endmodule

// File: doc/encoder_round_sched.md
Name: encoder_round_sched

Overview:
- Top-level scheduler for the matrix encoder.
- Sequences five function blocks (colParity, rotate, permute, revaluate, addRC) over a single shared 64-line x 25-bit state memory, for ROUNDS rounds.
- Owns the single memory write port. It pulses each stage's start, muxes the active stage's address and write signals onto the memory, and advances when that stage reports done.
- Adds a per-stage watchdog so a hung stage cannot lock the encoder.

Parameters:
- NUM_STG, 5, number of function stages, run in index order 0..NUM_STG-1.
- ROUNDS, 24, full passes over all stages per start.
- ADDR_W, 6, memory address width (64 lines).
- LINE_W, 25, memory line width (5x5 slice).
- TIMEOUT, 255, maximum WAIT cycles per stage before error.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin a run; sampled only in IDLE.
- busy  out  1  high from LAUNCH through DONE.
- done  out  1  one-cycle pulse when all rounds complete.
- error  out  1  sticky; set on watchdog expiry, cleared by rst or an accepted start.
- round_idx  out  5  current round, 0..ROUNDS-1.
- stage_idx  out  3  current stage, 0..NUM_STG-1.
- stg_start  out  NUM_STG  one-hot start pulse to the stages.
- stg_done  in  NUM_STG  per-stage done/carry-out.
- stg_addr  in  NUM_STG*ADDR_W  per-stage line counter, packed, stage 0 in the LSBs.
- stg_wr_en  in  NUM_STG  per-stage write enable.
- stg_wr_val  in  NUM_STG*LINE_W  per-stage write data, packed.
- mem_addr  out  ADDR_W  muxed memory address.
- mem_wr_en  out  1  muxed memory write enable.
- mem_wr_data  out  LINE_W  muxed memory write data.

Behaviour:
- Reset values: FSM in IDLE. busy, done, error = 0. round_idx, stage_idx = 0. stg_start = 0. mem_* = 0.
- rst mid-run aborts immediately and restores reset values on the next edge. No memory write occurs in the cycle after rst.
- FSM states: IDLE, LAUNCH, WAIT, DONE.
- IDLE:
  - start=1 -> LAUNCH with round_idx=0, stage_idx=0, error cleared.
  - start=0 -> stay.
- LAUNCH (exactly one cycle):
  - stg_start[stage_idx]=1; all other stg_start bits 0.
  - Watchdog counter cleared.
  - -> WAIT.
- WAIT:
  - Watchdog increments each cycle.
  - On stg_done[stage_idx]=1:
    - stage_idx < NUM_STG-1 -> stage_idx+1, LAUNCH.
    - Last stage and round_idx < ROUNDS-1 -> round_idx+1, stage_idx=0, LAUNCH.
    - Last stage of last round -> DONE.
  - Watchdog reaching TIMEOUT with no done -> error=1, IDLE, round_idx and stage_idx held for debug.
  - If done and timeout coincide in the same cycle, done wins.
- DONE (one cycle): done=1, busy=1. Then -> IDLE, where busy=0 and round_idx/stage_idx are held.
- stg_done from non-active stages is ignored in every state. stg_done is ignored in LAUNCH (a stage cannot finish in its start cycle). A done level held high is consumed only once, by the WAIT cycle.
- start while busy is ignored; no queuing.
- Memory mux:
  - Combinational select by stage_idx.
  - Active in LAUNCH and WAIT: mem_addr = stg_addr slice, mem_wr_en = stg_wr_en bit, mem_wr_data = stg_wr_val slice.
  - In IDLE and DONE, mem_wr_en=0 and mem_addr=0; mem_wr_data is don't-care but driven 0.
- Timing: latency per stage = 1 (LAUNCH) + N, where N is the cycle count from the WAIT entry until done is seen.
- Read data is broadcast to all stages outside this block.

Decomposition:
- Package encoder_pkg holds:
  - state enum {IDLE, LAUNCH, WAIT, DONE};
  - stage-index constants STG_COLPAR=0, STG_ROT=1, STG_PERM=2, STG_REVAL=3, STG_ADDRC=4;
  - LINE_W and ADDR_W defaults.
- One natural sub-module: sched_mem_mux, the parameterised packed-bus selector for address and write signals.

Test Plan:
- Normal run, ROUNDS=2, every stage model asserts done 3 cycles after its stg_start. Start sampled at cycle 0 -> stg_start pulses at cycles 1,5,9,...,37 with one-hot index 0..4 repeating. done pulses at cycle 41. busy=0 at cycle 42. round_idx=1 during cycles 21..41.
- Write muxing: stage 2 drives addr=0x2A, wr_en=1, data=0x1ABCDEF while stages 0,1,3,4 drive wr_en=1 with other values. During stage 2 WAIT, mem outputs equal the stage-2 values only. In IDLE, mem_wr_en=0.
- Spurious done: stg_done[3] held high while stage 1 is active, and stg_done[1] high during its LAUNCH cycle. Neither advances the sequence; stage 1 advances only on its first WAIT-cycle done.
- Watchdog, TIMEOUT=255: stage 0 never signals done -> error=1 after 255 WAIT cycles, FSM in IDLE, stage_idx=0. A new start clears error and the run proceeds normally.
- Reset mid-run: rst=1 during round 1 stage 3 -> next cycle busy=0, stg_start=0, mem_wr_en=0, round_idx=0, stage_idx=0. start is ignored while rst=1.
- Start while busy: extra start pulses at cycles 10 and 20 of a run -> no relaunch, timing identical to the normal run, exactly one done pulse.
